// File: rtl/fpu_arbiter.sv
// rtl/fpu_arbiter.sv - two-client arbiter/sequencer for one shared FPU; FPU_ARB_RR_EN selects round-robin over fixed priority
module fpu_arbiter #(
  parameter int LEN_FUNC3 = 3,
  parameter int LEN_FUNC7 = 7,
  parameter int LEN_WORD  = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 r0_order,
  input  logic                 r1_order,
  input  logic [LEN_FUNC3-1:0] r0_func3,
  input  logic [LEN_FUNC3-1:0] r1_func3,
  input  logic [LEN_FUNC7-1:0] r0_func7,
  input  logic [LEN_FUNC7-1:0] r1_func7,
  input  logic [LEN_WORD-1:0]  r0_rs1,
  input  logic [LEN_WORD-1:0]  r1_rs1,
  input  logic [LEN_WORD-1:0]  r0_rs2,
  input  logic [LEN_WORD-1:0]  r1_rs2,
  output logic                 r0_accepted,
  output logic                 r1_accepted,
  output logic                 r0_done,
  output logic                 r1_done,
  output logic [LEN_WORD-1:0]  r0_rd,
  output logic [LEN_WORD-1:0]  r1_rd,
  output logic                 f_order,
  output logic [LEN_FUNC3-1:0] f_func3,
  output logic [LEN_FUNC7-1:0] f_func7,
  output logic [LEN_WORD-1:0]  f_rs1,
  output logic [LEN_WORD-1:0]  f_rs2,
  input  logic                 f_accepted,
  input  logic                 f_done,
  input  logic [LEN_WORD-1:0]  f_rd
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ISSUE = 2'd1,
    S_WAIT  = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_owner;
  logic [LEN_FUNC3-1:0] r_func3;
  logic [LEN_FUNC7-1:0] r_func7;
  logic [LEN_WORD-1:0]  r_rs1;
  logic [LEN_WORD-1:0]  r_rs2;
  logic [LEN_WORD-1:0]  r_rd0;
  logic [LEN_WORD-1:0]  r_rd1;

  logic w_grant;
  logic w_winner;
  logic w_busy;
  logic w_done0;
  logic w_done1;

  // A grant happens only from IDLE; the loser keeps its order up and retries next IDLE
  assign w_grant = (r_state == S_IDLE) && (r0_order || r1_order);
  assign w_busy  = (r_state != S_IDLE);
  // f_done while IDLE cannot come from a correctly reset FPU, so it is ignored
  assign w_done0 = f_done && w_busy && !r_owner;
  assign w_done1 = f_done && w_busy &&  r_owner;

`ifdef FPU_ARB_RR_EN
  logic r_last;

  // On a tie the client that did not win last time gets the FPU
  assign w_winner = (r0_order && r1_order) ? ~r_last : r1_order;

  // Remember the most recent winner for the tie-break
  always_ff @(posedge clk) begin
    if (rst) begin
      r_last <= 1'b1;
    end else if (w_grant) begin
      r_last <= w_winner;
    end
  end
`else
  // Fixed priority: client 1 wins only when client 0 is not ordering
  assign w_winner = ~r0_order;
`endif

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state: ISSUE holds until the FPU accepts, WAIT holds until it finishes
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (r0_order || r1_order) begin
          w_state_nxt = S_ISSUE;
        end
      end
      S_ISSUE: begin
        if (f_accepted && f_done) begin
          w_state_nxt = S_IDLE;
        end else if (f_accepted) begin
          w_state_nxt = S_WAIT;
        end
      end
      S_WAIT: begin
        if (f_done) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Operand/owner latch on grant, and per-client result holding registers
  always_ff @(posedge clk) begin
    if (rst) begin
      r_owner <= 1'b0;
      r_func3 <= '0;
      r_func7 <= '0;
      r_rs1   <= '0;
      r_rs2   <= '0;
      r_rd0   <= '0;
      r_rd1   <= '0;
    end else begin
      if (w_grant) begin
        r_owner <= w_winner;
        r_func3 <= w_winner ? r1_func3 : r0_func3;
        r_func7 <= w_winner ? r1_func7 : r0_func7;
        r_rs1   <= w_winner ? r1_rs1   : r0_rs1;
        r_rs2   <= w_winner ? r1_rs2   : r0_rs2;
      end
      if (w_done0) begin
        r_rd0 <= f_rd;
      end
      if (w_done1) begin
        r_rd1 <= f_rd;
      end
    end
  end

  // Outputs: forced to zero while rst is high so nothing leaks during the reset cycle
  always_comb begin
    r0_accepted = 1'b0;
    r1_accepted = 1'b0;
    r0_done     = 1'b0;
    r1_done     = 1'b0;
    r0_rd       = '0;
    r1_rd       = '0;
    f_order     = 1'b0;
    f_func3     = '0;
    f_func7     = '0;
    f_rs1       = '0;
    f_rs2       = '0;
    if (!rst) begin
      r0_accepted = w_grant && !w_winner;
      r1_accepted = w_grant &&  w_winner;
      r0_done     = w_done0;
      r1_done     = w_done1;
      r0_rd       = w_done0 ? f_rd : r_rd0;
      r1_rd       = w_done1 ? f_rd : r_rd1;
      f_order     = (r_state == S_ISSUE);
      f_func3     = r_func3;
      f_func7     = r_func7;
      f_rs1       = r_rs1;
      f_rs2       = r_rs2;
    end
  end

endmodule

// File: tb/tb_fpu_arbiter.sv
// tb/tb_fpu_arbiter.sv - self-checking bench for fpu_arbiter with a behavioural FPU stub
module tb_fpu_arbiter;

  localparam logic [6:0] F_ADD = 7'b0000000;
  localparam logic [6:0] F_MUL = 7'b0001000;
  localparam logic [6:0] F_DIV = 7'b0001100;
  localparam logic [6:0] F_MVI = 7'b1111000;

  typedef struct packed {
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] a;
    logic [31:0] b;
  } job_t;

  logic        clk = 1'b0;
  logic        rst;
  logic        r0_order, r1_order;
  logic [2:0]  r0_func3, r1_func3;
  logic [6:0]  r0_func7, r1_func7;
  logic [31:0] r0_rs1, r1_rs1, r0_rs2, r1_rs2;
  logic        r0_accepted, r1_accepted, r0_done, r1_done;
  logic [31:0] r0_rd, r1_rd;
  logic        f_order;
  logic [2:0]  f_func3;
  logic [6:0]  f_func7;
  logic [31:0] f_rs1, f_rs2;
  logic        f_accepted, f_done;
  logic [31:0] f_rd;
  logic [142:0] w_all;

  assign w_all = {r0_accepted, r1_accepted, r0_done, r1_done, r0_rd, r1_rd,
                  f_order, f_func3, f_func7, f_rs1, f_rs2};

  always #5 clk = ~clk;

  fpu_arbiter #(.LEN_FUNC3(3), .LEN_FUNC7(7), .LEN_WORD(32)) dut (
    .clk(clk), .rst(rst),
    .r0_order(r0_order), .r1_order(r1_order),
    .r0_func3(r0_func3), .r1_func3(r1_func3),
    .r0_func7(r0_func7), .r1_func7(r1_func7),
    .r0_rs1(r0_rs1), .r1_rs1(r1_rs1), .r0_rs2(r0_rs2), .r1_rs2(r1_rs2),
    .r0_accepted(r0_accepted), .r1_accepted(r1_accepted),
    .r0_done(r0_done), .r1_done(r1_done),
    .r0_rd(r0_rd), .r1_rd(r1_rd),
    .f_order(f_order), .f_func3(f_func3), .f_func7(f_func7),
    .f_rs1(f_rs1), .f_rs2(f_rs2),
    .f_accepted(f_accepted), .f_done(f_done), .f_rd(f_rd)
  );

  // Stub FPU arithmetic: exact for the vectors named in the test plan, arbitrary but deterministic otherwise
  function automatic int op_lat(input logic [6:0] f7);
    case (f7)
      F_ADD:   return 3;
      F_MUL:   return 4;
      F_DIV:   return 10;
      default: return 0;
    endcase
  endfunction

  function automatic logic [31:0] op_res(input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
    case (f7)
      F_ADD:   return (a == 32'h3F800000 && b == 32'h40000000) ? 32'h40400000 : a + b;
      F_MUL:   return (a == 32'h40000000 && b == 32'h40400000) ? 32'h40C00000 : a ^ b;
      F_DIV:   return a - b;
      default: return a;
    endcase
  endfunction

  function automatic job_t mk(input logic [6:0] f7, input logic [31:0] a, input logic [31:0] b);
    return {3'b000, f7, a, b};
  endfunction

  // FPU stub: optional accept stall, zero-latency ops finish in the accept cycle
  logic        stub_busy;
  int          stub_cnt;
  int          stub_hold;
  int          stub_hold_cfg;
  logic [31:0] stub_res;

  always_comb begin
    f_accepted = 1'b0;
    f_done     = 1'b0;
    f_rd       = '0;
    if (stub_busy) begin
      if (stub_cnt == 0) begin
        f_done = 1'b1;
        f_rd   = stub_res;
      end
    end else if (f_order && stub_hold >= stub_hold_cfg) begin
      f_accepted = 1'b1;
      if (op_lat(f_func7) == 0) begin
        f_done = 1'b1;
        f_rd   = op_res(f_func7, f_rs1, f_rs2);
      end
    end
  end

  always @(posedge clk) begin
    if (rst) begin
      stub_busy <= 1'b0;
      stub_cnt  <= 0;
      stub_hold <= 0;
    end else begin
      if (stub_busy) begin
        if (stub_cnt == 0) stub_busy <= 1'b0;
        else               stub_cnt  <= stub_cnt - 1;
      end else if (f_accepted && !f_done) begin
        stub_busy <= 1'b1;
        stub_cnt  <= op_lat(f_func7) - 1;
        stub_res  <= op_res(f_func7, f_rs1, f_rs2);
      end
      if (f_order && !f_accepted) stub_hold <= stub_hold + 1;
      else                        stub_hold <= 0;
    end
  end

  // Client job queues, scoreboard (expected/observed) and event logs
  job_t        cq0[$], cq1[$];
  logic [31:0] exp0[$], exp1[$], obs0[$], obs1[$];
  int          ord0[$], ord1[$], acc0[$], acc1[$], dn0[$], dn1[$], fo[$];
  bit          gq[$];
  int          cyc;
  int          n_cmp;
  int          n_bad;
  bit          s_acc0, s_acc1, s_fo;

  task automatic clear_logs();
    cq0.delete(); cq1.delete(); exp0.delete(); exp1.delete(); obs0.delete(); obs1.delete();
    ord0.delete(); ord1.delete(); acc0.delete(); acc1.delete(); dn0.delete(); dn1.delete();
    fo.delete(); gq.delete();
    s_acc0 = 1'b0; s_acc1 = 1'b0; s_fo = 1'b0;
  endtask

  // One clock: clients drop/raise orders after the edge, outputs are logged mid-cycle
  task automatic tick();
    job_t j;
    @(posedge clk); #1;
    cyc++;
    if (s_acc0) r0_order = 1'b0;
    if (s_acc1) r1_order = 1'b0;
    if (!r0_order && cq0.size() != 0) begin
      j = cq0.pop_front();
      r0_func3 = j.f3; r0_func7 = j.f7; r0_rs1 = j.a; r0_rs2 = j.b; r0_order = 1'b1;
      ord0.push_back(cyc);
    end
    if (!r1_order && cq1.size() != 0) begin
      j = cq1.pop_front();
      r1_func3 = j.f3; r1_func7 = j.f7; r1_rs1 = j.a; r1_rs2 = j.b; r1_order = 1'b1;
      ord1.push_back(cyc);
    end
    @(negedge clk);
    s_acc0 = r0_accepted;
    s_acc1 = r1_accepted;
    if (r0_accepted) begin acc0.push_back(cyc); gq.push_back(1'b0); end
    if (r1_accepted) begin acc1.push_back(cyc); gq.push_back(1'b1); end
    if (f_order && !s_fo) fo.push_back(cyc);
    s_fo = f_order;
    if (r0_done) begin obs0.push_back(r0_rd); dn0.push_back(cyc); end
    if (r1_done) begin obs1.push_back(r1_rd); dn1.push_back(cyc); end
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1; r0_order = 1'b0; r1_order = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic drain(input int bound, output bit ok);
    int n = 0;
    while ((cq0.size() != 0 || cq1.size() != 0 || r0_order || r1_order ||
            obs0.size() < exp0.size() || obs1.size() < exp1.size()) && n < bound) begin
      tick();
      n++;
    end
    ok = (n < bound);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    r0_order = 1'b1; r1_order = 1'b1;
    r0_rs1 = 32'hFFFFFFFF; r1_rs1 = 32'hFFFFFFFF;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if (w_all !== '0) begin n_bad++; $display("FAIL reset_outputs: got %h, expected 0", w_all); end
    @(posedge clk); #1;
    r0_order = 1'b0; r1_order = 1'b0;
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (w_all !== '0) begin n_bad++; $display("FAIL idle_after_reset: got %h, expected 0", w_all); end
    clear_logs();
  endtask

  task automatic test_single_c0();
    int n = 0;
    bit bad1 = 1'b0;
    do_reset();
    cq0.push_back(mk(F_ADD, 32'h3F800000, 32'h40000000));
    exp0.push_back(32'h40400000);
    while (dn0.size() == 0 && n < 40) begin
      tick(); n++;
      if (r1_done !== 1'b0 || r1_rd !== 32'h0) bad1 = 1'b1;
    end
    n_cmp++;
    if (dn0.size() == 0 || acc0.size() == 0 || fo.size() == 0) begin
      n_bad++; $display("FAIL c0_fadd_timeout: got no completion, expected r0_done");
    end else begin
      n_cmp += 3;
      if (acc0[0] !== ord0[0]) begin n_bad++; $display("FAIL c0_accept_cycle: got %0d, expected %0d", acc0[0], ord0[0]); end
      if (fo[0] !== ord0[0] + 1) begin n_bad++; $display("FAIL c0_forder_cycle: got %0d, expected %0d", fo[0], ord0[0] + 1); end
      if (dn0[0] !== ord0[0] + 4) begin n_bad++; $display("FAIL c0_done_cycle: got %0d, expected %0d", dn0[0], ord0[0] + 4); end
      if (obs0[0] !== exp0[0]) begin n_bad++; $display("FAIL c0_fadd_rd: got %h, expected %h", obs0[0], exp0[0]); end
    end
    n_cmp++;
    if (bad1) begin n_bad++; $display("FAIL c1_undisturbed: got activity on client 1, expected none"); end
  endtask

  task automatic test_single_c1();
    int n = 0;
    do_reset();
    cq1.push_back(mk(F_MVI, 32'h12345678, 32'h0));
    exp1.push_back(32'h12345678);
    while (dn1.size() == 0 && n < 20) begin tick(); n++; end
    n_cmp++;
    if (dn1.size() == 0) begin
      n_bad++; $display("FAIL c1_fmvi_timeout: got no completion, expected r1_done");
    end else begin
      n_cmp += 2;
      if (dn1[0] !== ord1[0] + 1) begin n_bad++; $display("FAIL c1_done_cycle: got %0d, expected %0d", dn1[0], ord1[0] + 1); end
      if (obs1[0] !== exp1[0]) begin n_bad++; $display("FAIL c1_fmvi_rd: got %h, expected %h", obs1[0], exp1[0]); end
    end
    for (int i = 0; i < 10; i++) begin
      tick();
      n_cmp++;
      if (r1_rd !== 32'h12345678 || r1_done !== 1'b0 || r0_rd !== 32'h0) begin
        n_bad++; $display("FAIL c1_rd_hold[%0d]: got r1_rd=%h r1_done=%b r0_rd=%h, expected 12345678/0/0", i, r1_rd, r1_done, r0_rd);
      end
    end
  endtask

  task automatic test_both();
    bit ok;
    do_reset();
    cq0.push_back(mk(F_MUL, 32'h40000000, 32'h40400000));
    exp0.push_back(32'h40C00000);
    cq1.push_back(mk(F_MVI, 32'hDEADBEEF, 32'h0));
    exp1.push_back(32'hDEADBEEF);
    drain(60, ok);
    n_cmp++;
    if (!ok || gq.size() != 2 || dn0.size() == 0 || acc1.size() == 0) begin
      n_bad++; $display("FAIL both_timeout: got %0d grants, expected 2", gq.size());
    end else begin
      n_cmp += 5;
      if (gq[0] !== 1'b0) begin n_bad++; $display("FAIL both_first_grant: got %0d, expected 0", gq[0]); end
      if (ord1[0] !== ord0[0]) begin n_bad++; $display("FAIL both_same_cycle: got %0d, expected %0d", ord1[0], ord0[0]); end
      if (acc1[0] !== dn0[0] + 1) begin n_bad++; $display("FAIL both_c1_grant_cycle: got %0d, expected %0d", acc1[0], dn0[0] + 1); end
      if (obs0[0] !== exp0[0]) begin n_bad++; $display("FAIL both_c0_rd: got %h, expected %h", obs0[0], exp0[0]); end
      if (obs1[0] !== exp1[0]) begin n_bad++; $display("FAIL both_c1_rd: got %h, expected %h", obs1[0], exp1[0]); end
    end
  endtask

  task automatic test_reset_in_wait();
    int n = 0;
    do_reset();
    cq0.push_back(mk(F_DIV, 32'h40800000, 32'h40000000));
    while (acc0.size() == 0 && n < 10) begin tick(); n++; end
    tick(); tick();
    n_cmp++;
    if (f_order !== 1'b0) begin n_bad++; $display("FAIL div_in_wait: got f_order=%b, expected 0", f_order); end
    @(posedge clk); #1;
    rst = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (w_all !== '0) begin n_bad++; $display("FAIL reset_mid_op_outputs: got %h, expected 0", w_all); end
    @(posedge clk); #1;
    rst = 1'b0;
    clear_logs();
    repeat (15) tick();
    n_cmp++;
    if (dn0.size() != 0 || r0_rd !== 32'h0) begin
      n_bad++; $display("FAIL reset_drops_op: got %0d dones r0_rd=%h, expected 0/0", dn0.size(), r0_rd);
    end
    clear_logs();
    cq0.push_back(mk(F_MVI, 32'h00000001, 32'h0));
    exp0.push_back(32'h00000001);
    n = 0;
    while (dn0.size() == 0 && n < 20) begin tick(); n++; end
    n_cmp++;
    if (dn0.size() == 0) begin
      n_bad++; $display("FAIL post_reset_timeout: got no completion, expected r0_done");
    end else begin
      n_cmp += 2;
      if (dn0[0] - acc0[0] !== 1 || acc0[0] !== ord0[0]) begin
        n_bad++; $display("FAIL post_reset_latency: got %0d, expected 1", dn0[0] - acc0[0]);
      end
      if (obs0[0] !== exp0[0]) begin n_bad++; $display("FAIL post_reset_rd: got %h, expected %h", obs0[0], exp0[0]); end
    end
  endtask

  task automatic test_accept_stall();
    bit ok;
    do_reset();
    stub_hold_cfg = 3;
    cq0.push_back(mk(F_ADD, 32'h3F800000, 32'h40000000));
    exp0.push_back(32'h40400000);
    tick();
    cq1.push_back(mk(F_MVI, 32'hA5A5A5A5, 32'h0));
    exp1.push_back(32'hA5A5A5A5);
    for (int i = 0; i < 3; i++) begin
      tick();
      n_cmp++;
      if (f_order !== 1'b1 || f_func7 !== F_ADD || f_rs1 !== 32'h3F800000 ||
          f_rs2 !== 32'h40000000 || r1_accepted !== 1'b0) begin
        n_bad++; $display("FAIL stall_stable[%0d]: got order=%b f7=%h rs1=%h rs2=%h acc1=%b, expected 1/00/3f800000/40000000/0",
                          i, f_order, f_func7, f_rs1, f_rs2, r1_accepted);
      end
    end
    drain(80, ok);
    stub_hold_cfg = 0;
    n_cmp++;
    if (!ok || dn0.size() == 0 || acc1.size() == 0 || obs1.size() == 0) begin
      n_bad++; $display("FAIL stall_timeout: got %0d grants, expected 2", gq.size());
    end else begin
      n_cmp += 3;
      if (acc1[0] !== dn0[0] + 1) begin n_bad++; $display("FAIL stall_c1_grant: got %0d, expected %0d", acc1[0], dn0[0] + 1); end
      if (obs0[0] !== exp0[0]) begin n_bad++; $display("FAIL stall_c0_rd: got %h, expected %h", obs0[0], exp0[0]); end
      if (obs1[0] !== exp1[0]) begin n_bad++; $display("FAIL stall_c1_rd: got %h, expected %h", obs1[0], exp1[0]); end
    end
  endtask

`ifdef FPU_ARB_RR_EN
  task automatic test_round_robin();
    bit ok;
    logic [31:0] v;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      v = $urandom; cq0.push_back(mk(F_MVI, v, 32'h0)); exp0.push_back(v);
      v = $urandom; cq1.push_back(mk(F_MVI, v, 32'h0)); exp1.push_back(v);
    end
    drain(200, ok);
    n_cmp++;
    if (!ok || gq.size() != 20) begin
      n_bad++; $display("FAIL rr_timeout: got %0d grants, expected 20", gq.size());
    end else begin
      for (int i = 0; i < 20; i++) begin
        n_cmp++;
        if (gq[i] !== i[0]) begin n_bad++; $display("FAIL rr_order[%0d]: got %0d, expected %0d", i, gq[i], i[0]); end
      end
      for (int i = 0; i < 9; i++) begin
        n_cmp++;
        if (acc0[i+1] - acc0[i] !== 4 || acc1[i+1] - acc1[i] !== 4) begin
          n_bad++; $display("FAIL rr_interval[%0d]: got %0d/%0d, expected 4/4", i, acc0[i+1] - acc0[i], acc1[i+1] - acc1[i]);
        end
      end
    end
    for (int i = 0; i < exp0.size(); i++) begin
      n_cmp++;
      if (i >= obs0.size() || obs0[i] !== exp0[i]) begin n_bad++; $display("FAIL rr_c0_rd[%0d]: expected %h", i, exp0[i]); end
    end
    for (int i = 0; i < exp1.size(); i++) begin
      n_cmp++;
      if (i >= obs1.size() || obs1[i] !== exp1[i]) begin n_bad++; $display("FAIL rr_c1_rd[%0d]: expected %h", i, exp1[i]); end
    end
  endtask
`else
  task automatic test_starvation();
    bit ok;
    logic [31:0] v;
    do_reset();
    for (int i = 0; i < 20; i++) begin
      v = $urandom; cq0.push_back(mk(F_MVI, v, 32'h0)); exp0.push_back(v);
    end
    cq1.push_back(mk(F_MVI, 32'h0BADF00D, 32'h0));
    exp1.push_back(32'h0BADF00D);
    drain(300, ok);
    n_cmp++;
    if (!ok || gq.size() != 21) begin
      n_bad++; $display("FAIL fp_timeout: got %0d grants, expected 21", gq.size());
    end else begin
      for (int i = 0; i < 20; i++) begin
        n_cmp++;
        if (gq[i] !== 1'b0) begin n_bad++; $display("FAIL fp_grant[%0d]: got %0d, expected 0", i, gq[i]); end
      end
    end
    for (int i = 0; i < exp0.size(); i++) begin
      n_cmp++;
      if (i >= obs0.size() || obs0[i] !== exp0[i]) begin n_bad++; $display("FAIL fp_c0_rd[%0d]: expected %h", i, exp0[i]); end
    end
    n_cmp++;
    if (obs1.size() == 0 || obs1[0] !== exp1[0]) begin n_bad++; $display("FAIL fp_c1_rd: expected %h", exp1[0]); end
  endtask
`endif

  initial begin
    #300000;
    $display("FAIL watchdog: got no finish, expected completion within time limit");
    $fatal(1);
  end

  initial begin
    n_cmp = 0; n_bad = 0; cyc = 0;
    stub_hold_cfg = 0;
    rst = 1'b1;
    r0_order = 1'b0; r1_order = 1'b0;
    r0_func3 = '0; r1_func3 = '0; r0_func7 = '0; r1_func7 = '0;
    r0_rs1 = '0; r1_rs1 = '0; r0_rs2 = '0; r1_rs2 = '0;
    clear_logs();
    test_reset();
    test_single_c0();
    test_single_c1();
    test_both();
    test_reset_in_wait();
    test_accept_stall();
`ifdef FPU_ARB_RR_EN
    test_round_robin();
`else
    test_starvation();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
